// File: rtl/multi_src_stream_ctrl.sv
// multi_src_stream_ctrl
//   Session controller for N_SRC producers sharing one CDC FIFO write port.
//   Edge-detects per-producer start requests and a common stop, grants one
//   producer per session, forwards its words to the FIFO, stalls while the
//   FIFO is full and waits for the FIFO to drain after stop. Also counts the
//   words of the current session and registers the parity of FIFO read data.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   start[N_SRC]      level request per producer, rising edge starts session
//   stop              level, rising edge ends the session
//   src_valid/data    producer valids and packed data (slice k = [k*DW +: DW])
//   buf_full/empty    FIFO flags
//   rd_valid/data     FIFO read side, only used for drain exit and parity
//   src_en            one-hot enable of the granted producer while RUN
//   active_id         index of the granted producer
//   wr_en/wr_data     registered FIFO write port
//   state, busy       controller state and state != IDLE
//   word_cnt          saturating word count of the current/last session
//   parity            registered parity of rd_data
//
// State table
//   state | meaning
//   IDLE  | no session, waiting for a start edge
//   RUN   | granted producer enabled, words forwarded to FIFO
//   WAIT  | FIFO full, producer paused
//   DRAIN | stop seen, waiting for FIFO empty and no read in flight

module multi_src_stream_ctrl #(
  parameter int N_SRC      = 4,
  parameter int DW         = 16,
  parameter int CW         = 16,
  parameter int ODD_PARITY = 0,
  localparam int IW        = $clog2(N_SRC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    start,
  input  logic                stop,
  input  logic [N_SRC-1:0]    src_valid,
  input  logic [N_SRC*DW-1:0] src_data,
  input  logic                buf_full,
  input  logic                buf_empty,
  input  logic                rd_valid,
  input  logic [DW-1:0]       rd_data,
  output logic [N_SRC-1:0]    src_en,
  output logic [IW-1:0]       active_id,
  output logic                wr_en,
  output logic [DW-1:0]       wr_data,
  output logic [1:0]          state,
  output logic                busy,
  output logic [CW-1:0]       word_cnt,
  output logic                parity
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DRAIN = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] start_prev_q, start_prev_d;
  logic             stop_prev_q, stop_prev_d;
  logic [IW-1:0]    active_id_q, active_id_d;
  logic             wr_en_q, wr_en_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic [CW-1:0]    word_cnt_q, word_cnt_d;
  logic             parity_q, parity_d;

  logic [N_SRC-1:0] start_edge;
  logic             stop_edge;
  logic [IW-1:0]    first_id;
  logic             session_start;
  logic             sel_valid;
  logic [DW-1:0]    sel_data;

  assign start_edge    = start & ~start_prev_q;
  assign stop_edge     = stop & ~stop_prev_q;
  assign session_start = (state_q == ST_IDLE) && (|start_edge);

  // Lowest index wins when several start edges arrive together.
  always_comb begin
    first_id = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (start_edge[k]) first_id = IW'(k);
    end
  end

  // Granted producer mux
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (active_id_q == IW'(k)) begin
        sel_valid = src_valid[k];
        sel_data  = src_data[k*DW +: DW];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. Stop takes priority over full in RUN and WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|start_edge) state_d = ST_RUN;
      ST_RUN: begin
        if (stop_edge)     state_d = ST_DRAIN;
        else if (buf_full) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (stop_edge)      state_d = ST_DRAIN;
        else if (!buf_full) state_d = ST_RUN;
      end
      ST_DRAIN: if (buf_empty && !rd_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs, decoded from registers only
  always_comb begin
    busy = (state_q != ST_IDLE);
    for (int k = 0; k < N_SRC; k++) begin
      src_en[k] = (state_q == ST_RUN) && (active_id_q == IW'(k));
    end
  end

  // Datapath next values
  always_comb begin
    start_prev_d = start;
    stop_prev_d  = stop;
    active_id_d  = session_start ? first_id : active_id_q;
    // Full gates the same edge it is sampled on, so no word is written into
    // a full FIFO.
    wr_en_d      = (state_q == ST_RUN) && sel_valid && !buf_full;
    wr_data_d    = wr_en_d ? sel_data : wr_data_q;
    word_cnt_d   = word_cnt_q;
    if (session_start) begin
      word_cnt_d = '0;
    end else if (wr_en_q && (word_cnt_q != {CW{1'b1}})) begin
      word_cnt_d = word_cnt_q + CW'(1);
    end
    parity_d     = (^rd_data) ^ (ODD_PARITY != 0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev_q <= '0;
      stop_prev_q  <= 1'b0;
      active_id_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      word_cnt_q   <= '0;
      parity_q     <= 1'b0;
    end else begin
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      active_id_q  <= active_id_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      word_cnt_q   <= word_cnt_d;
      parity_q     <= parity_d;
    end
  end

  assign state     = state_q;
  assign active_id = active_id_q;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign word_cnt  = word_cnt_q;
  assign parity    = parity_q;

endmodule

// File: tb/tb_multi_src_stream_ctrl.sv
module tb_multi_src_stream_ctrl;

  localparam int ODD = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start;
  logic        stop;
  logic [3:0]  src_valid;
  logic [63:0] src_data;
  logic        buf_full, buf_empty, rd_valid;
  logic [15:0] rd_data;

  logic [3:0]  src_en, src_en_s;
  logic [1:0]  active_id, active_id_s;
  logic        wr_en, wr_en_s;
  logic [15:0] wr_data, wr_data_s;
  logic [1:0]  state, state_s;
  logic        busy, busy_s;
  logic [15:0] word_cnt;
  logic [2:0]  word_cnt_s;
  logic        parity, parity_s;

  int checks = 0;
  int failures = 0;

  multi_src_stream_ctrl #(.N_SRC(4), .DW(16), .CW(16), .ODD_PARITY(ODD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .src_valid(src_valid), .src_data(src_data),
    .buf_full(buf_full), .buf_empty(buf_empty),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .src_en(src_en), .active_id(active_id), .wr_en(wr_en), .wr_data(wr_data),
    .state(state), .busy(busy), .word_cnt(word_cnt), .parity(parity)
  );

  multi_src_stream_ctrl #(.N_SRC(4), .DW(16), .CW(3), .ODD_PARITY(ODD)) dut_s (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .src_valid(src_valid), .src_data(src_data),
    .buf_full(buf_full), .buf_empty(buf_empty),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .src_en(src_en_s), .active_id(active_id_s), .wr_en(wr_en_s),
    .wr_data(wr_data_s), .state(state_s), .busy(busy_s),
    .word_cnt(word_cnt_s), .parity(parity_s)
  );

  always #5 clk = ~clk;

  // Reference model: session flags, saturating counters, parity by popcount
  bit          m_sess, m_drain, m_stall;
  int          m_id, m_cnt, m_cnt3;
  bit          m_wr_en, m_par;
  logic [15:0] m_wr_data;
  logic [3:0]  m_sprev;
  bit          m_tprev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sess = 0; m_drain = 0; m_stall = 0; m_id = 0; m_cnt = 0; m_cnt3 = 0;
    m_wr_en = 0; m_par = 0; m_wr_data = '0; m_sprev = '0; m_tprev = 0;
  endtask

  task automatic model_update();
    logic [3:0]  se;
    bit          te, nwr;
    logic [15:0] slice;
    if (rst) begin
      model_reset();
      return;
    end
    se    = start & ~m_sprev;
    te    = stop & ~m_tprev;
    slice = src_data[m_id*16 +: 16];
    nwr   = m_sess && !m_drain && !m_stall && src_valid[m_id] && !buf_full;
    if (m_wr_en) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt3 < 7) m_cnt3++;
    end
    if (!m_sess) begin
      if (se != 4'b0) begin
        m_sess = 1; m_cnt = 0; m_cnt3 = 0;
        for (int k = 3; k >= 0; k--) if (se[k]) m_id = k;
      end
    end else if (m_drain) begin
      if (buf_empty && !rd_valid) begin m_sess = 0; m_drain = 0; end
    end else if (te) begin
      m_drain = 1; m_stall = 0;
    end else begin
      m_stall = buf_full;
    end
    m_wr_en = nwr;
    if (nwr) m_wr_data = slice;
    m_par   = (($countones(rd_data) % 2) == 1) ^ (ODD != 0);
    m_sprev = start;
    m_tprev = stop;
  endtask

  task automatic compare_all();
    logic [1:0] es;
    logic [3:0] een;
    es  = !m_sess ? 2'd0 : m_drain ? 2'd3 : m_stall ? 2'd2 : 2'd1;
    een = (es == 2'd1) ? 4'(1 << m_id) : 4'b0;
    chk("m_state",    64'(state),      64'(es));
    chk("m_busy",     64'(busy),       64'(es != 2'd0));
    chk("m_src_en",   64'(src_en),     64'(een));
    chk("m_active",   64'(active_id),  64'(m_id));
    chk("m_wr_en",    64'(wr_en),      64'(m_wr_en));
    chk("m_wr_data",  64'(wr_data),    64'(m_wr_data));
    chk("m_word_cnt", 64'(word_cnt),   64'(m_cnt));
    chk("m_parity",   64'(parity),     64'(m_par));
    chk("m_cnt_cw3",  64'(word_cnt_s), 64'(m_cnt3));
    chk("m_state_s",  64'(state_s),    64'(es));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  start;
    logic        stop;
    logic [3:0]  valid;
    logic [15:0] d;
    logic [15:0] rdd;
    logic [1:0]  e_state;
    logic [1:0]  e_id;
    logic        e_wr;
    logic [15:0] e_wd;
    logic [15:0] e_cnt;
    logic        e_par;
  } vec_t;

  vec_t tbl[16];
  int   pulses;

  initial begin
    // slot k carries d ^ (((k^2)&3) << 12): slot 2 = d, slot 1 = d ^ 0x3000
    tbl[0]  = '{4'b0100, 1'b0, 4'b0000, 16'h0000, 16'h0000, 2'd1, 2'd2, 1'b0, 16'h0000, 16'd0, 1'b0};
    tbl[1]  = '{4'b0100, 1'b0, 4'b0100, 16'h0001, 16'h0007, 2'd1, 2'd2, 1'b1, 16'h0001, 16'd0, 1'b1};
    tbl[2]  = '{4'b0100, 1'b0, 4'b0100, 16'h0002, 16'h0003, 2'd1, 2'd2, 1'b1, 16'h0002, 16'd1, 1'b0};
    tbl[3]  = '{4'b0000, 1'b0, 4'b0100, 16'h0003, 16'h0001, 2'd1, 2'd2, 1'b1, 16'h0003, 16'd2, 1'b1};
    tbl[4]  = '{4'b0000, 1'b0, 4'b0100, 16'h0004, 16'h0000, 2'd1, 2'd2, 1'b1, 16'h0004, 16'd3, 1'b0};
    tbl[5]  = '{4'b0000, 1'b0, 4'b0100, 16'h0005, 16'h0000, 2'd1, 2'd2, 1'b1, 16'h0005, 16'd4, 1'b0};
    tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 16'h0006, 16'h0000, 2'd1, 2'd2, 1'b0, 16'h0005, 16'd5, 1'b0};
    tbl[7]  = '{4'b0000, 1'b0, 4'b1000, 16'h0009, 16'h0000, 2'd1, 2'd2, 1'b0, 16'h0005, 16'd5, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 16'h0007, 16'h0000, 2'd3, 2'd2, 1'b0, 16'h0005, 16'd5, 1'b0};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 16'h0000, 16'h0000, 2'd0, 2'd2, 1'b0, 16'h0005, 16'd5, 1'b0};
    tbl[10] = '{4'b1010, 1'b0, 4'b0000, 16'h0000, 16'h0000, 2'd1, 2'd1, 1'b0, 16'h0005, 16'd0, 1'b0};
    tbl[11] = '{4'b0010, 1'b0, 4'b0010, 16'h3011, 16'h0000, 2'd1, 2'd1, 1'b1, 16'h0011, 16'd0, 1'b0};
    tbl[12] = '{4'b1010, 1'b0, 4'b0000, 16'h0000, 16'h0000, 2'd1, 2'd1, 1'b0, 16'h0011, 16'd1, 1'b0};
    tbl[13] = '{4'b1010, 1'b0, 4'b0010, 16'h3012, 16'h0000, 2'd1, 2'd1, 1'b1, 16'h0012, 16'd1, 1'b0};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000, 16'h0000, 16'h0000, 2'd3, 2'd1, 1'b0, 16'h0012, 16'd2, 1'b0};
    tbl[15] = '{4'b0000, 1'b0, 4'b0000, 16'h0000, 16'h0000, 2'd0, 2'd1, 1'b0, 16'h0012, 16'd2, 1'b0};

    rst = 1'b1; start = '0; stop = 1'b0; src_valid = '0; src_data = '0;
    buf_full = 1'b0; buf_empty = 1'b1; rd_valid = 1'b0; rd_data = '0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; src_valid = tbl[i].valid;
      rd_data = tbl[i].rdd; buf_full = 1'b0; buf_empty = 1'b1; rd_valid = 1'b0;
      for (int k = 0; k < 4; k++)
        src_data[k*16 +: 16] = tbl[i].d ^ 16'(((k ^ 2) & 3) << 12);
      step();
      chk($sformatf("tv%0d_state", i), 64'(state), 64'(tbl[i].e_state));
      chk($sformatf("tv%0d_id", i), 64'(active_id), 64'(tbl[i].e_id));
      chk($sformatf("tv%0d_src_en", i), 64'(src_en),
          64'((tbl[i].e_state == 2'd1) ? 4'(1 << tbl[i].e_id) : 4'b0));
      chk($sformatf("tv%0d_wr_en", i), 64'(wr_en), 64'(tbl[i].e_wr));
      chk($sformatf("tv%0d_wr_data", i), 64'(wr_data), 64'(tbl[i].e_wd));
      chk($sformatf("tv%0d_cnt", i), 64'(word_cnt), 64'(tbl[i].e_cnt));
      chk($sformatf("tv%0d_parity", i), 64'(parity), 64'(tbl[i].e_par));
    end

    // Stall on full for three cycles, producer 0
    start = 4'b0001; src_valid = 4'b0001; src_data = '0; stop = 1'b0;
    step();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      src_data[15:0] = 16'(i + 1);
      buf_full = (i >= 2 && i <= 4);
      step();
      if (wr_en) pulses++;
      if (i >= 2 && i <= 4) begin
        chk("stall_state", 64'(state), 64'd2);
        chk("stall_src_en", 64'(src_en), 64'd0);
        chk("stall_wr_en", 64'(wr_en), 64'd0);
      end
      if (i == 5) chk("stall_resume", 64'(state), 64'd1);
    end
    chk("stall_pulses", 64'(pulses), 64'd4);
    chk("stall_last_data", 64'(wr_data), 64'h8);

    // Stop together with full, then drain
    stop = 1'b1; buf_full = 1'b1; buf_empty = 1'b0; src_valid = '0; start = '0;
    step();
    chk("stop_full_drain", 64'(state), 64'd3);
    buf_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_hold", 64'(state), 64'd3);
    end
    buf_empty = 1'b1; rd_valid = 1'b1;
    step();
    chk("drain_rd_valid", 64'(state), 64'd3);
    rd_valid = 1'b0;
    step();
    chk("drain_exit", 64'(state), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_cnt_held", 64'(word_cnt), 64'd4);
    stop = 1'b0;
    step();
    chk("idle_cnt_held", 64'(word_cnt), 64'd4);

    // Saturation with CW=3 and parity
    start = 4'b1000;
    step();
    src_valid = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      src_data[63:48] = 16'(16'h0100 + i);
      rd_data = (i == 3) ? 16'h0007 : (i == 4) ? 16'h0003 : 16'h0000;
      step();
      if (i == 3) chk("parity_0007", 64'(parity), 64'd1);
      if (i == 4) chk("parity_0003", 64'(parity), 64'd0);
    end
    src_valid = '0;
    step();
    step();
    chk("cnt16_ten", 64'(word_cnt), 64'd10);
    chk("cnt3_sat", 64'(word_cnt_s), 64'd7);
    stop = 1'b1; start = '0;
    step();
    step();
    stop = 1'b0;
    step();

    // Reset mid-session with wr_en high, start held through release
    start = 4'b0100; src_valid = 4'b0100; src_data[47:32] = 16'hABCD;
    step();
    step();
    chk("pre_rst_wr_en", 64'(wr_en), 64'd1);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_src_en", 64'(src_en), 64'd0);
    @(negedge clk);
    step();
    rst = 1'b0;
    step();
    chk("rst_release_run", 64'(state), 64'd1);
    chk("rst_release_id", 64'(active_id), 64'd2);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) start = 4'($urandom);
      if ($urandom_range(0, 7) == 0) stop = ~stop;
      src_valid = 4'($urandom);
      src_data  = {$urandom, $urandom};
      buf_full  = ($urandom_range(0, 4) == 0);
      buf_empty = ($urandom_range(0, 1) == 0);
      rd_valid  = ($urandom_range(0, 2) == 0);
      rd_data   = 16'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
